// File: rtl/seg_scan_hex_n.sv
// seg_scan_hex_n - multiplexed seven-segment hex display driver.
//
// Scans NUM_DIGITS common-select digits, one nibble per digit, with per-digit
// decimal point and enable, leading-zero blanking, 16-level brightness PWM
// and a double-buffered input set that only reaches the display at a frame
// boundary, so a frame is never drawn from a half-updated value.
//
// Ports:
//   sys_clk      in   system clock, rising edge
//   sys_rst_n    in   synchronous active-low reset
//   data         in   4*NUM_DIGITS nibbles, data[3:0] = digit 0 (rightmost)
//   dp           in   decimal point per digit
//   en           in   digit enable (0 = digit fully blank)
//   lz_suppress  in   leading-zero blanking enable
//   brightness   in   on-time of (brightness+1)/16 of each dwell
//   load         in   strobe capturing all display inputs into the pending set
//   seg_sel      out  digit select, one-hot active
//   seg_led      out  segments, bit7 = dp, bits6..0 = g..a
//   frame_done   out  one-cycle pulse when the scan wraps to digit 0
module seg_scan_hex_n #(
    parameter int NUM_DIGITS     = 6,
    parameter int CLK_FREQ       = 50000000,
    parameter int SCAN_HZ        = 1000,
    parameter int SEL_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic [4*NUM_DIGITS-1:0]   data,
    input  logic [NUM_DIGITS-1:0]     dp,
    input  logic [NUM_DIGITS-1:0]     en,
    input  logic                      lz_suppress,
    input  logic [3:0]                brightness,
    input  logic                      load,
    output logic [NUM_DIGITS-1:0]     seg_sel,
    output logic [7:0]                seg_led,
    output logic                      frame_done
);

    localparam int DWELL = CLK_FREQ / SCAN_HZ;
    localparam int SLICE = DWELL / 16;
    localparam int SW    = (SLICE > 1) ? $clog2(SLICE) : 1;
    localparam int DW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [SW-1:0] SLICE_LAST = SW'(SLICE - 1);
    localparam logic [DW-1:0] DIG_LAST   = DW'(NUM_DIGITS - 1);

    // Idle output levels; XOR with these also applies the output polarity.
    localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{SEL_ACTIVE_LOW != 0}};
    localparam logic [7:0]            SEG_OFF = {8{SEG_ACTIVE_LOW != 0}};

    // Scan counters
    logic [SW-1:0] r_slice;
    logic [3:0]    r_ph;
    logic [DW-1:0] r_dig;

    // Pending set (written by load) and active set (what is displayed)
    logic [4*NUM_DIGITS-1:0] r_p_data, r_a_data;
    logic [NUM_DIGITS-1:0]   r_p_dp,   r_a_dp;
    logic [NUM_DIGITS-1:0]   r_p_en,   r_a_en;
    logic                    r_p_lz,   r_a_lz;
    logic [3:0]              r_p_bri,  r_a_bri;

    logic                    w_slice_wrap;
    logic                    w_ph_wrap;
    logic                    w_bound;
    logic [NUM_DIGITS-1:0]   w_cur;
    logic [3:0]              w_nib;
    logic                    w_dp_cur;
    logic                    w_en_cur;
    logic                    w_zero;
    logic                    w_supp;
    logic                    w_on;
    logic [NUM_DIGITS-1:0]   w_sel;
    logic [7:0]              w_seg;

    assign w_slice_wrap = (r_slice == SLICE_LAST);
    assign w_ph_wrap    = w_slice_wrap && (r_ph == 4'hF);
    assign w_bound      = w_ph_wrap && (r_dig == DIG_LAST);

    function automatic logic [6:0] f_decode(input logic [3:0] n);
        case (n)
            4'h0: f_decode = 7'h3F;
            4'h1: f_decode = 7'h06;
            4'h2: f_decode = 7'h5B;
            4'h3: f_decode = 7'h4F;
            4'h4: f_decode = 7'h66;
            4'h5: f_decode = 7'h6D;
            4'h6: f_decode = 7'h7D;
            4'h7: f_decode = 7'h07;
            4'h8: f_decode = 7'h7F;
            4'h9: f_decode = 7'h6F;
            4'hA: f_decode = 7'h77;
            4'hB: f_decode = 7'h7C;
            4'hC: f_decode = 7'h39;
            4'hD: f_decode = 7'h5E;
            4'hE: f_decode = 7'h79;
            default: f_decode = 7'h71;
        endcase
    endfunction

    always_comb begin
        w_cur    = '0;
        w_nib    = '0;
        w_dp_cur = 1'b0;
        w_en_cur = 1'b0;
        w_zero   = 1'b1;
        w_supp   = 1'b0;
        w_on     = 1'b0;
        w_sel    = '0;
        w_seg    = '0;
        // Walk from the top digit down so w_zero means "this digit and every
        // digit above it reads as zero" (disabled digits read as zero).
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (r_a_en[NUM_DIGITS-1-k] && (r_a_data[4*(NUM_DIGITS-1-k) +: 4] != 4'h0))
                w_zero = 1'b0;
            if (DW'(NUM_DIGITS - 1 - k) == r_dig) begin
                w_cur[NUM_DIGITS-1-k] = 1'b1;
                w_nib    = r_a_data[4*(NUM_DIGITS-1-k) +: 4];
                w_dp_cur = r_a_dp[NUM_DIGITS-1-k];
                w_en_cur = r_a_en[NUM_DIGITS-1-k];
                w_supp   = r_a_lz && (k != NUM_DIGITS - 1) && w_zero;
            end
        end
        if (w_en_cur && (r_ph <= r_a_bri)) begin
            if (!w_supp) begin
                w_on  = 1'b1;
                w_seg = {w_dp_cur, f_decode(w_nib)};
            end else if (w_dp_cur) begin
                // Blanked leading zero still shows its decimal point.
                w_on  = 1'b1;
                w_seg = 8'h80;
            end
        end
        if (w_on)
            w_sel = w_cur;
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_slice    <= '0;
            r_ph       <= '0;
            r_dig      <= '0;
            r_p_data   <= '0;
            r_p_dp     <= '0;
            r_p_en     <= '0;
            r_p_lz     <= 1'b0;
            r_p_bri    <= '0;
            r_a_data   <= '0;
            r_a_dp     <= '0;
            r_a_en     <= '0;
            r_a_lz     <= 1'b0;
            r_a_bri    <= '0;
            seg_sel    <= SEL_OFF;
            seg_led    <= SEG_OFF;
            frame_done <= 1'b0;
        end else begin
            r_slice <= w_slice_wrap ? '0 : r_slice + 1'b1;
            if (w_slice_wrap)
                r_ph <= r_ph + 4'h1;
            if (w_ph_wrap)
                r_dig <= (r_dig == DIG_LAST) ? '0 : r_dig + 1'b1;

            if (load) begin
                r_p_data <= data;
                r_p_dp   <= dp;
                r_p_en   <= en;
                r_p_lz   <= lz_suppress;
                r_p_bri  <= brightness;
            end
            // A load coinciding with the boundary bypasses the pending set.
            if (w_bound) begin
                r_a_data <= load ? data        : r_p_data;
                r_a_dp   <= load ? dp          : r_p_dp;
                r_a_en   <= load ? en          : r_p_en;
                r_a_lz   <= load ? lz_suppress : r_p_lz;
                r_a_bri  <= load ? brightness  : r_p_bri;
            end

            frame_done <= w_bound;
            seg_sel    <= w_sel ^ SEL_OFF;
            seg_led    <= w_seg ^ SEG_OFF;
        end
    end

endmodule

// File: tb/tb_seg_scan_hex_n.sv
module tb_seg_scan_hex_n;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  dp = '0, en = '0, bri = '0;
    logic        lz = 1'b0, load = 1'b0;
    logic [3:0]  sel;
    logic [7:0]  led;
    logic        fd;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    seg_scan_hex_n #(
        .NUM_DIGITS(4), .CLK_FREQ(1600), .SCAN_HZ(100),
        .SEL_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
    ) dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .data(data), .dp(dp), .en(en),
        .lz_suppress(lz), .brightness(bri), .load(load),
        .seg_sel(sel), .seg_led(led), .frame_done(fd)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [6:0]  lut [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [15:0] pd, ad;
    logic [3:0]  pdp, adp, pen, aen, pbri, abri;
    logic        plz, alz;
    int          m_t = 0;
    bit          m_valid = 0;
    bit          bnd;
    logic [3:0]  e_sel;
    logic [7:0]  e_led;
    logic        e_fd;

    // Display of digit dg at phase ph (0..15) from the active set, active-low.
    function automatic void model_out(input int dg, input int ph,
                                      output logic [3:0] s, output logic [7:0] l);
        bit zero = 1;
        bit supp;
        s = 4'hF;
        l = 8'hFF;
        for (int k = dg; k < 4; k++)
            if (aen[k] && ad[4*k +: 4] != 4'h0) zero = 0;
        supp = alz && (dg > 0) && zero;
        if (aen[dg] && ph <= int'(abri)) begin
            if (!supp) begin
                s = ~(4'b0001 << dg);
                l = ~{adp[dg], lut[ad[4*dg +: 4]]};
            end else if (adp[dg]) begin
                s = ~(4'b0001 << dg);
                l = 8'h7F;
            end
        end
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid = 1;
            m_t = 0;
            {pd, pdp, pen, pbri, plz} = '0;
            {ad, adp, aen, abri, alz} = '0;
            e_sel = 4'hF;
            e_led = 8'hFF;
            e_fd = 1'b0;
        end else if (m_valid) begin
            bnd = (m_t % 64) == 63;
            model_out((m_t / 16) % 4, m_t % 16, e_sel, e_led);
            e_fd = bnd;
            if (bnd) begin
                if (load) {ad, adp, aen, abri, alz} = {data, dp, en, bri, lz};
                else      {ad, adp, aen, abri, alz} = {pd, pdp, pen, pbri, plz};
            end
            if (load) {pd, pdp, pen, pbri, plz} = {data, dp, en, bri, lz};
            m_t++;
        end
        #1;
        if (m_valid) begin
            check("model_sel", {28'h0, sel}, {28'h0, e_sel});
            check("model_led", {24'h0, led}, {24'h0, e_led});
            check("model_fd",  {31'h0, fd},  {31'h0, e_fd});
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic wait_fd(input int limit, output int n);
        n = 0;
        while (n < limit) begin
            @(posedge clk); #2;
            n++;
            if (fd === 1'b1) return;
        end
        total++;
        bad++;
        $display("FAIL wait_fd: no frame_done within %0d cycles (expected a pulse)", limit);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] e,
                           input logic l, input logic [3:0] b);
        @(negedge clk);
        data = d; dp = p; en = e; lz = l; bri = b; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        int n, c_on, c_off;
        logic [3:0] s_arr [4];
        logic [7:0] l_arr [4];

        // 1: reset, idle scan
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_fd(200, n);
        check("s1_fd_first", n, 64);
        wait_fd(200, n);
        check("s1_fd_period", n, 64);
        check("s1_idle_sel", {28'h0, sel}, 32'hF);
        check("s1_idle_led", {24'h0, led}, 32'hFF);

        // 2: full brightness 12AF
        do_load(16'h12AF, 4'h0, 4'hF, 1'b0, 4'd15);
        wait_fd(200, n);
        c_on = 0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #2;
            if (sel == 4'hE && led == 8'h8E) c_on++;
        end
        check("s2_dig0_dwell", c_on, 16);
        repeat (32) @(posedge clk);
        c_on = 0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #2;
            if (sel == 4'h7 && led == 8'hF9) c_on++;
        end
        check("s2_dig3_dwell", c_on, 16);
        check("s2_fd_align", {31'h0, fd}, 32'h1);

        // 3: brightness 3
        do_load(16'h0008, 4'h0, 4'hF, 1'b0, 4'd3);
        wait_fd(200, n);
        c_on = 0;
        c_off = 0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #2;
            if (i < 4 && sel == 4'hE && led == 8'h80) c_on++;
            if (i >= 4 && sel == 4'hF && led == 8'hFF) c_off++;
        end
        check("s3_on_cycles", c_on, 4);
        check("s3_off_cycles", c_off, 12);

        // 4: leading-zero suppression
        do_load(16'h0050, 4'b0100, 4'hF, 1'b1, 4'd15);
        wait_fd(200, n);
        for (int i = 0; i < 64; i++) begin
            @(posedge clk); #2;
            if (i % 16 == 0) begin
                s_arr[i/16] = sel;
                l_arr[i/16] = led;
            end
        end
        check("s4_d0_sel", {28'h0, s_arr[0]}, 32'hE);
        check("s4_d0_led", {24'h0, l_arr[0]}, 32'hC0);
        check("s4_d1_sel", {28'h0, s_arr[1]}, 32'hD);
        check("s4_d1_led", {24'h0, l_arr[1]}, 32'h92);
        check("s4_d2_sel", {28'h0, s_arr[2]}, 32'hB);
        check("s4_d2_led", {24'h0, l_arr[2]}, 32'h7F);
        check("s4_d3_sel", {28'h0, s_arr[3]}, 32'hF);
        check("s4_d3_led", {24'h0, l_arr[3]}, 32'hFF);

        // 5: mid-frame loads, last wins; coincident load
        repeat (10) @(posedge clk);
        do_load(16'h1111, 4'h0, 4'hF, 1'b0, 4'd15);
        repeat (10) @(posedge clk);
        do_load(16'h2222, 4'h0, 4'hF, 1'b0, 4'd15);
        @(posedge clk); #2;
        check("s5_unchanged_sel", {28'h0, sel}, 32'hD);
        check("s5_unchanged_led", {24'h0, led}, 32'h92);
        wait_fd(200, n);
        @(posedge clk); #2;
        check("s5_new_led", {24'h0, led}, 32'hA4);
        repeat (62) @(posedge clk);
        @(negedge clk);
        data = 16'h3333; load = 1'b1;
        @(posedge clk); #2;
        check("s5_fd_coincide", {31'h0, fd}, 32'h1);
        @(negedge clk);
        load = 1'b0;
        @(posedge clk); #2;
        check("s5_coincide_sel", {28'h0, sel}, 32'hE);
        check("s5_coincide_led", {24'h0, led}, 32'hB0);

        // 6: reset during digit 2
        repeat (36) @(posedge clk);
        #2;
        check("s6_dig2_on", {28'h0, sel}, 32'hB);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #2;
        check("s6_rst_sel", {28'h0, sel}, 32'hF);
        check("s6_rst_led", {24'h0, led}, 32'hFF);
        check("s6_rst_fd", {31'h0, fd}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #2;
        check("s6_blank_led", {24'h0, led}, 32'hFF);
        wait_fd(200, n);
        check("s6_fd_restart", n, 63);

        // random phase
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 399) != 0);
            load = ($urandom_range(0, 15) == 0);
            if (load) begin
                for (int k = 0; k < 4; k++)
                    data[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
                dp  = 4'($urandom_range(0, 15));
                en  = 4'($urandom_range(0, 15));
                lz  = 1'($urandom_range(0, 1));
                bri = 4'($urandom_range(0, 15));
            end
        end
        @(negedge clk);
        load = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
